// File: rtl/rv32i_types.sv
// Shared types for the cache-to-memory arbiter.
//   arb_state_t : arbiter FSM states
//   arb_src_t   : which cache owns the current memory transaction
//   STARVE_W    : width of the I-side starvation counter (holds 0..15)
package rv32i_types;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/cache_arb_ctrl.sv
// Arbitration FSM for the shared memory line port.
// Decides which cache owns memory, drives the registered memory strobes and
// cache response pulses, and tracks how long the I-side has been starved.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_read                      I-cache line read request
//   dmem_read, dmem_write          D-cache line read / writeback request
//   pmem_resp                      memory completion pulse
//   grant, grant_src               one-cycle grant strobe and its owner (latch enable for the top)
//   capture_i, capture_d           load pmem_rdata into that side's buffer
//   pmem_read, pmem_write          registered memory strobes
//   imem_resp, dmem_resp           registered one-cycle completion pulses
module cache_arb_ctrl
  import rv32i_types::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     imem_read,
  input  logic     dmem_read,
  input  logic     dmem_write,
  input  logic     pmem_resp,
  output logic     grant,
  output arb_src_t grant_src,
  output logic     capture_i,
  output logic     capture_d,
  output logic     pmem_read,
  output logic     pmem_write,
  output logic     imem_resp,
  output logic     dmem_resp
);

  localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_MAX);

  arb_state_t          state_reg;
  logic [STARVE_W-1:0] starve_cnt_reg;
  logic                pmem_read_reg;
  logic                pmem_write_reg;
  logic                imem_resp_reg;
  logic                dmem_resp_reg;

  logic d_req;
  logic i_starved;
  logic pick_d;
  logic pick_i;

  // D wins by default; only a saturated starvation count hands the port to I.
  assign d_req     = dmem_read | dmem_write;
  assign i_starved = imem_read && (starve_cnt_reg == STARVE_MAX_C);
  assign pick_d    = (state_reg == IDLE) && d_req && !i_starved;
  assign pick_i    = (state_reg == IDLE) && imem_read && !pick_d;

  assign grant     = pick_d | pick_i;
  assign grant_src = pick_d ? SRC_D : SRC_I;
  assign capture_i = (state_reg == BUSY_I) && pmem_resp;
  assign capture_d = (state_reg == BUSY_D) && pmem_resp;

  assign pmem_read  = pmem_read_reg;
  assign pmem_write = pmem_write_reg;
  assign imem_resp  = imem_resp_reg;
  assign dmem_resp  = dmem_resp_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      pmem_read_reg  <= 1'b0;
      pmem_write_reg <= 1'b0;
      imem_resp_reg  <= 1'b0;
      dmem_resp_reg  <= 1'b0;
    end else begin
      imem_resp_reg <= 1'b0;
      dmem_resp_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_d) begin
            state_reg <= BUSY_D;
            // Read+write together is illegal; the write takes precedence.
            pmem_write_reg <= dmem_write;
            pmem_read_reg  <= !dmem_write;
            if (!imem_read)
              starve_cnt_reg <= '0;
            else if (starve_cnt_reg != STARVE_MAX_C)
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
          end else if (pick_i) begin
            state_reg      <= BUSY_I;
            pmem_read_reg  <= 1'b1;
            starve_cnt_reg <= '0;
          end
        end
        BUSY_I: begin
          if (pmem_resp) begin
            state_reg      <= RESP_I;
            pmem_read_reg  <= 1'b0;
            pmem_write_reg <= 1'b0;
            imem_resp_reg  <= 1'b1;
          end
        end
        BUSY_D: begin
          if (pmem_resp) begin
            state_reg      <= RESP_D;
            pmem_read_reg  <= 1'b0;
            pmem_write_reg <= 1'b0;
            dmem_resp_reg  <= 1'b1;
          end
        end
        // The response cycle never grants, so the cache that was just
        // answered gets a cycle to drop its request.
        RESP_I, RESP_D: state_reg <= IDLE;
        default:        state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory line port between the I-cache miss path and the
// D-cache miss/writeback path. D has fixed priority, bounded by a starvation
// counter; one transaction is outstanding at a time.
// Ports:
//   clk, rst                                  clock, synchronous active-high reset
//   imem_read/imem_addr -> imem_rdata/resp    I-cache line fill
//   dmem_read/dmem_write/dmem_addr/dmem_wdata
//                       -> dmem_rdata/resp    D-cache fill / writeback
//   pmem_read/pmem_write/pmem_addr/pmem_wdata
//                       <- pmem_rdata/resp    memory line port
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W     = 256,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_read,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [LINE_W-1:0] imem_rdata,
  output logic              imem_resp,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [LINE_W-1:0] dmem_wdata,
  output logic [LINE_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  logic     grant;
  arb_src_t grant_src;
  logic     capture_i;
  logic     capture_d;

  cache_arb_ctrl #(
    .STARVE_MAX(STARVE_MAX)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .imem_read (imem_read),
    .dmem_read (dmem_read),
    .dmem_write(dmem_write),
    .pmem_resp (pmem_resp),
    .grant     (grant),
    .grant_src (grant_src),
    .capture_i (capture_i),
    .capture_d (capture_d),
    .pmem_read (pmem_read),
    .pmem_write(pmem_write),
    .imem_resp (imem_resp),
    .dmem_resp (dmem_resp)
  );

  // Request fields are latched on the grant edge so requesters may change
  // them freely while their transaction is in flight.
  logic [ADDR_W-1:0] addr_reg;
  logic [LINE_W-1:0] wdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (grant) begin
      if (grant_src == SRC_D) begin
        addr_reg  <= dmem_addr;
        wdata_reg <= dmem_wdata;
      end else begin
        addr_reg  <= imem_addr;
      end
    end
  end

  assign pmem_addr  = addr_reg;
  assign pmem_wdata = wdata_reg;

  // Per-side read buffers (index 0 = I, 1 = D); each holds its last line
  // until that side's next completion.
  logic              capture [2];
  logic [LINE_W-1:0] rdata_reg [2];

  assign capture[0] = capture_i;
  assign capture[1] = capture_d;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rbuf
      always_ff @(posedge clk) begin
        if (rst)
          rdata_reg[gi] <= '0;
        else if (capture[gi])
          rdata_reg[gi] <= pmem_rdata;
      end
    end
  endgenerate

  assign imem_rdata = rdata_reg[0];
  assign dmem_rdata = rdata_reg[1];

  // Simultaneous D read and write is a caller bug.
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(dmem_read && dmem_write));

endmodule
